// File: rtl/ahb_master_if.sv
// Single-outstanding AHB-Lite master bridging a CPU request/response port to an
// instruction slave (HSEL1) and a data slave (HSEL2). Optional wait-state timeout: AHB_TIMEOUT_EN.
module ahb_master_if #(
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE       = 32'h1000_0000,
  parameter int          REGION_BITS    = 16,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        is_signed,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic        muxsel,
  input  logic [31:0] instruction,
  input  logic [31:0] load_out,
  input  logic        hready_inst,
  input  logic        hready_data,
  input  logic        hresp_inst,
  input  logic        hresp_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

  localparam logic [31:0] RMASK = ~((32'h1 << REGION_BITS) - 32'h1);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("ahb_master_if: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic [31:0] cap_wdata;
  logic        cap_sel_data;

  logic hit_rom, hit_ram, local_err, sel_ready, sel_resp;

  assign hit_rom = (req_addr & RMASK) == (ROM_BASE & RMASK);
  assign hit_ram = (req_addr & RMASK) == (RAM_BASE & RMASK);

  // Anything the slaves could not legally serve is answered locally, never put on the bus.
  assign local_err = !(hit_rom || hit_ram)
                   || (req_size > 3'd2)
                   || (req_size == 3'd1 && req_addr[0])
                   || (req_size == 3'd2 && req_addr[1:0] != 2'b00)
                   || (req_write && hit_rom);

  assign sel_ready = cap_sel_data ? hready_data : hready_inst;
  assign sel_resp  = cap_sel_data ? hresp_data  : hresp_inst;

  assign req_ready = (state == IDLE);
  assign hprot     = 4'b0011;

`ifdef AHB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cap_wdata    <= '0;
      cap_sel_data <= 1'b0;
      haddr        <= '0;
      hwdata       <= '0;
      hwrite       <= 1'b0;
      hsize        <= '0;
      is_signed    <= 1'b0;
      htrans       <= 2'b00;
      HSEL1        <= 1'b0;
      HSEL2        <= 1'b0;
      muxsel       <= 1'b0;
`ifdef AHB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          haddr        <= req_addr;
          cap_wdata    <= req_wdata;
          hwrite       <= req_write;
          hsize        <= req_size;
          is_signed    <= req_signed;
          cap_sel_data <= !hit_rom;
          if (local_err) begin
            state <= ERR;
          end else begin
            state  <= ADDR;
            htrans <= 2'b10;
            HSEL1  <= hit_rom;
            HSEL2  <= !hit_rom;
            muxsel <= !hit_rom;
          end
        end
        ADDR: begin
          state  <= DATA;
          htrans <= 2'b00;
          hwdata <= cap_wdata;
`ifdef AHB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        DATA: begin
          if (sel_ready) begin
            state <= IDLE;
            HSEL1 <= 1'b0;
            HSEL2 <= 1'b0;
            muxsel <= 1'b0;
          end
`ifdef AHB_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            state  <= ERR;
            HSEL1  <= 1'b0;
            HSEL2  <= 1'b0;
            muxsel <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion follows the selected slave's hready in the same cycle.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (state == DATA && sel_ready) begin
      rsp_valid = 1'b1;
      rsp_err   = sel_resp;
      rsp_rdata = cap_sel_data ? load_out : instruction;
    end else if (state == ERR) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: decode, latency, wait states, local errors, reset abort.
module tb_ahb_master_if;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, haddr, hwdata, instruction, load_out;
  logic        hwrite, is_signed, HSEL1, HSEL2, muxsel;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready_inst, hready_data, hresp_inst, hresp_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ahb_master_if dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .hsize(hsize), .hprot(hprot), .htrans(htrans), .is_signed(is_signed),
    .HSEL1(HSEL1), .HSEL2(HSEL2), .muxsel(muxsel),
    .instruction(instruction), .load_out(load_out),
    .hready_inst(hready_inst), .hready_data(hready_data),
    .hresp_inst(hresp_inst), .hresp_data(hresp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic sg, input logic [31:0] wd);
    req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz;
    req_signed = sg; req_wdata = wd;
  endtask

  initial begin
    reset = 1'b0; req_valid = 0; req_addr = 0; req_wdata = 0; req_write = 0;
    req_size = 0; req_signed = 0; instruction = 0; load_out = 0;
    hready_inst = 1; hready_data = 1; hresp_inst = 0; hresp_data = 0;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_hprot", hprot, 4'b0011);
    chk("rst_htrans", htrans, 0);
    chk("rst_hsel", {HSEL1, HSEL2, muxsel}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_haddr", haddr, 0);
    cyc();
    reset = 1'b1;

    // word load from data slave
    load_out = 32'hDEAD_BEEF;
    req(32'h1000_0010, 0, 3'd2, 0, 0);
    #1 chk("ld_ready_idle", req_ready, 1);
    cyc(); req_valid = 0; #1;
    chk("ld_addr_htrans", htrans, 2'b10);
    chk("ld_addr_sel", {HSEL1, HSEL2, muxsel}, 3'b011);
    chk("ld_addr_hsize", hsize, 2);
    chk("ld_addr_haddr", haddr, 32'h1000_0010);
    chk("ld_addr_hwrite", hwrite, 0);
    chk("ld_addr_hprot", hprot, 4'b0011);
    chk("ld_addr_rsp", rsp_valid, 0);
    chk("ld_addr_ready", req_ready, 0);
    cyc();
    chk("ld_data_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("ld_data_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ld_data_htrans", htrans, 0);
    cyc();
    chk("ld_idle_rsp", rsp_valid, 0);
    chk("ld_idle_ready", req_ready, 1);

    // fetch with 3 wait states; data-side signals toggled to show they are ignored
    instruction = 32'h1357_9BDF; hready_inst = 0; hresp_data = 1;
    req(32'h0000_0004, 0, 3'd2, 0, 0);
    cyc(); req_valid = 0; #1;
    chk("if_addr_sel", {HSEL1, HSEL2, muxsel}, 3'b100);
    chk("if_addr_htrans", htrans, 2'b10);
    cyc(); chk("if_wait1", rsp_valid, 0);
    cyc(); chk("if_wait2", rsp_valid, 0);
    cyc(); chk("if_wait3", rsp_valid, 0);
    chk("if_wait_sel", {HSEL1, muxsel}, 2'b10);
    cyc(); hready_inst = 1;
    req(32'h1000_0001, 1, 3'd1, 0, 32'h1234);
    #1;
    chk("if_rsp_c5", {rsp_valid, rsp_err}, 2'b10);
    chk("if_rdata", rsp_rdata, 32'h1357_9BDF);
    hresp_data = 0;

    // back-to-back: misaligned half store then decode miss, both local errors
    cyc();
    chk("b2b_ready", req_ready, 1);
    chk("b2b_rsp_low", rsp_valid, 0);
    cyc();
    chk("hs_err_rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("hs_err_rdata", rsp_rdata, 0);
    chk("hs_err_bus", {htrans, HSEL1, HSEL2}, 0);
    req(32'h2000_0000, 0, 3'd2, 0, 0);
    cyc();
    chk("dm_idle_rsp", rsp_valid, 0);
    cyc(); req_valid = 0; #1;
    chk("dm_err_rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("dm_err_bus", {htrans, HSEL1, HSEL2}, 0);
    cyc();

    // store to instruction region, size 3, misaligned word: each a local error
    req(32'h0000_0100, 1, 3'd2, 0, 0);
    cyc(); req_valid = 0; #1;
    chk("rom_st_err", {rsp_valid, rsp_err, htrans}, 4'b1100);
    cyc();
    req(32'h1000_0000, 0, 3'd3, 0, 0);
    cyc(); req_valid = 0; #1;
    chk("sz3_err", {rsp_valid, rsp_err, HSEL2}, 3'b110);
    cyc();
    req(32'h1000_0002, 0, 3'd2, 0, 0);
    cyc(); req_valid = 0; #1;
    chk("wmis_err", {rsp_valid, rsp_err}, 2'b11);
    cyc();

    // byte store with slave error response
    hresp_data = 1;
    req(32'h1000_0003, 1, 3'd0, 0, 32'h0000_00AB);
    cyc(); req_valid = 0; #1;
    chk("bs_addr", {hwrite, hsize, HSEL2, htrans}, {1'b1, 3'd0, 1'b1, 2'b10});
    cyc();
    chk("bs_hwdata", hwdata, 32'h0000_00AB);
    chk("bs_rsp", {rsp_valid, rsp_err}, 2'b11);
    cyc(); hresp_data = 0;

    // signed half load
    load_out = 32'hFFFF_8001;
    req(32'h1000_0002, 0, 3'd1, 1, 0);
    cyc(); req_valid = 0; #1;
    chk("sh_addr", {is_signed, hsize}, {1'b1, 3'd1});
    cyc();
    chk("sh_rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("sh_rdata", rsp_rdata, 32'hFFFF_8001);
    cyc();

    // long wait on data slave
    hready_data = 0; load_out = 32'h0BAD_F00D;
    req(32'h1000_0000, 0, 3'd2, 0, 0);
    cyc(); req_valid = 0; cyc();
    begin
      int early = 0;
      for (int i = 1; i < 16; i++) begin
        if (rsp_valid !== 1'b0) early++;
        cyc();
      end
      chk("wait_quiet_15", early, 0);
    end
    chk("wait_c16", rsp_valid, 0);
    cyc();
`ifdef AHB_TIMEOUT_EN
    chk("to_err", {rsp_valid, rsp_err}, 2'b11);
    chk("to_rdata", rsp_rdata, 0);
    cyc();
    chk("to_idle", {req_ready, rsp_valid}, 2'b10);
`else
    chk("nto_still_wait", {rsp_valid, req_ready}, 2'b00);
    cyc(); cyc(); hready_data = 1; #1;
    chk("nto_done", {rsp_valid, rsp_err}, 2'b10);
    chk("nto_rdata", rsp_rdata, 32'h0BAD_F00D);
    cyc();
`endif

    // reset in DATA abandons the transfer
    hready_data = 0;
    req(32'h1000_0004, 0, 3'd2, 0, 0);
    cyc(); req_valid = 0; cyc();
    reset = 1'b0; hready_data = 1; #1;
    chk("rstm_idle", {req_ready, htrans, HSEL2, muxsel}, 5'b10000);
    chk("rstm_no_rsp", rsp_valid, 0);
    cyc();
    chk("rstm_still_no_rsp", rsp_valid, 0);
    reset = 1'b1;
    req(32'h0000_0008, 0, 3'd2, 0, 0);
    cyc(); req_valid = 0; #1;
    chk("rstm_first_acc", {HSEL1, htrans}, 3'b110);
    cyc();
    chk("rstm_first_rsp", rsp_valid, 1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_master_if.md
AHB_MASTER_IF -- requirements
Module: ahb_master_if

Interface
REQ-001 SHALL have parameter ROM_BASE, 32'h0000_0000, base of instruction region (HSEL1).
REQ-002 SHALL have parameter RAM_BASE, 32'h1000_0000, base of data region (HSEL2).
REQ-003 SHALL have parameter REGION_BITS, 16, log2 of region size in bytes.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 16, wait-state limit (timeout feature only).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  in  1  CPU request.
REQ-008 SHALL have port req_ready  out  1  request accepted this cycle.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data.
REQ-011 SHALL have port req_write  in  1  1=store, 0=load/fetch.
REQ-012 SHALL have port req_size  in  3  0=byte, 1=half, 2=word.
REQ-013 SHALL have port req_signed  in  1  sign-extend loads.
REQ-014 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata  out  32  read result.
REQ-016 SHALL have port rsp_err  out  1  error, qualified by rsp_valid.
REQ-017 SHALL have ports haddr/hwdata  out  32 each  AHB address / write data.
REQ-018 SHALL have ports hwrite 1, hsize 3, hprot 4, htrans 2, is_signed 1, HSEL1 1, HSEL2 1, muxsel 1, all out, to slave side.
REQ-019 SHALL have ports instruction/load_out  in  32 each  slave read data.
REQ-020 SHALL have ports hready_inst, hready_data, hresp_inst, hresp_data  in  1 each.

Function
REQ-021 SHALL implement FSM IDLE, ADDR, DATA, ERR; at most one outstanding transfer, no address/data overlap.
REQ-022 req_ready SHALL be 1 only in IDLE; request captured into registers when req_valid & req_ready.
REQ-023 Decode: addr[31:REGION_BITS]==ROM_BASE[31:REGION_BITS] -> inst slave; ==RAM_BASE[31:REGION_BITS] -> data slave; else decode error.
REQ-024 Local error (decode miss, req_size>2, half with addr[0]=1, word with addr[1:0]!=0, store to inst region) SHALL go IDLE->ERR with no bus activity (htrans=0, HSEL1=HSEL2=0).
REQ-025 Legal request: IDLE->ADDR; ADDR drives htrans=2'b10, haddr, hwrite, hsize, is_signed, hprot=4'b0011, one HSELx=1, muxsel=1 for data slave; next cycle ADDR->DATA.
REQ-026 DATA SHALL drive hwdata=captured wdata, htrans=0, hold HSELx/muxsel, wait while selected hready=0.
REQ-027 DATA with selected hready=1: rsp_valid=1 that cycle, rsp_rdata=instruction or load_out, rsp_err=selected hresp; next state IDLE.
REQ-028 ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle, then IDLE.
REQ-029 Minimum latency accept->rsp_valid: 2 cycles legal, 1 cycle local error; back-to-back accept in the cycle after rsp_valid.
REQ-030 rsp_valid SHALL be 0 in every cycle not listed in REQ-027/028; unselected hready/hresp SHALL be ignored.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE; all outputs 0 except req_ready=1, hprot=4'b0011; captured registers 0.
REQ-032 Reset mid-transfer SHALL abandon it with no rsp_valid; first request accepted on first edge after release.

Configuration
REQ-033 AHB_TIMEOUT_EN defined: counter in DATA increments per hready=0 cycle; at TIMEOUT_CYCLES consecutive waits go DATA->ERR (rsp_err=1), counter cleared on DATA entry. Undefined: DATA waits indefinitely, no counter logic.

Verification
REQ-034 Word load 0x1000_0010, hready_data=1, load_out=0xDEAD_BEEF -> HSEL2=1, hsize=2 in ADDR; rsp_valid 2 cycles after accept, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-035 Fetch 0x0000_0004, hready_inst low 3 cycles -> HSEL1=1, muxsel=0, rsp_valid exactly 5 cycles after accept, rsp_rdata=instruction.
REQ-036 Half store to 0x1000_0001; then load 0x2000_0000 -> each rsp_valid+rsp_err 1 cycle after accept, htrans stays 0.
REQ-037 Byte store 0x1000_0003 data 0xAB, hresp_data=1 with hready_data=1 -> hwdata=0x0000_00AB in DATA, rsp_err=1.
REQ-038 AHB_TIMEOUT_EN, TIMEOUT_CYCLES=16, hready_data held 0 -> rsp_err=1 after 16 wait cycles; reset asserted in DATA -> IDLE immediately, no rsp_valid.
